cv32e40p_x_acc_resp: RTL and testbench

Accelerator-side responder for the cv32e40p X-interface, i.e. the coprocessor end that the core's dispatcher offloads to. It decodes offloaded custom-opcode instructions and accepts or rejects them. Accepted instructions are buffered in an in-order queue and executed one at a time. ALU ops write back over the result channel; load/store ops are handed back to the core through the xmem request/response channels.

---
 rtl/cv32e40p_x_acc_resp.sv | 227 ++++++++++++++++++++++
 tb/tb_cv32e40p_x_acc_resp.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_x_acc_resp.sv
// rtl/cv32e40p_x_acc_resp.sv - X-interface accelerator responder: decode, in-order queue, ALU/xmem execution FSM.
// Optional MAC op (funct3=011) enabled by defining CV32E40P_X_ACC_MAC_EN.

package cv32e40p_x_if_pkg;
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } mem_req_type_e;
endpackage

module cv32e40p_x_acc_resp
  import cv32e40p_x_if_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter int          LATENCY = 2,
  parameter logic [6:0]  OPCODE  = 7'h0B
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          x_valid_i,
  output logic          x_ready_o,
  input  logic [31:0]   x_instr_i,
  input  logic [95:0]   x_rs_i,
  input  logic [2:0]    x_rs_valid_i,
  input  logic          x_rd_clean_i,
  output logic          x_accept_o,
  output logic          x_writeback_o,
  output logic          x_is_mem_op_o,
  output logic          x_rvalid_o,
  input  logic          x_rready_i,
  output logic [4:0]    x_rwaddr_o,
  output logic [31:0]   x_rdata_o,
  output logic          xmem_valid_o,
  input  logic          xmem_ready_i,
  output mem_req_type_e xmem_req_type_o,
  output logic [31:0]   xmem_addr_o,
  output logic [31:0]   xmem_wdata_o,
  input  logic          xmem_rvalid_i,
  output logic          xmem_rready_o,
  input  logic [31:0]   xmem_rdata_i,
  input  logic          xmem_status_i,
  output logic          err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, EXEC, MEM_REQ, MEM_RSP, RESULT} state_e;

  state_e state_q, state_d;

  // Decode of the instruction currently offered by the core
  logic [6:0] dec_opc;
  logic [2:0] dec_f3;
  logic [4:0] dec_rd;
  logic       dec_hit, dec_alu, dec_mac, dec_ld, dec_st, recognised, rs_ok;

  assign dec_opc = x_instr_i[6:0];
  assign dec_rd  = x_instr_i[11:7];
  assign dec_f3  = x_instr_i[14:12];
  assign dec_hit = (dec_opc == OPCODE);
`ifdef CV32E40P_X_ACC_MAC_EN
  assign dec_mac = dec_hit & (dec_f3 == 3'b011);
`else
  assign dec_mac = 1'b0;
`endif
  assign dec_alu    = dec_hit & ((dec_f3 == 3'b000) | (dec_f3 == 3'b001) | (dec_f3 == 3'b010) | dec_mac);
  assign dec_ld     = dec_hit & (dec_f3 == 3'b100);
  assign dec_st     = dec_hit & (dec_f3 == 3'b101);
  assign recognised = dec_alu | dec_ld | dec_st;
  assign rs_ok      = x_rs_valid_i[0] & (dec_ld | x_rs_valid_i[1]) & (~dec_mac | x_rs_valid_i[2]);

  // Queue storage and pointers
  logic [2:0]    q_f3  [DEPTH];
  logic [4:0]    q_rd  [DEPTH];
  logic [31:0]   q_rs1 [DEPTH];
  logic [31:0]   q_rs2 [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          full, empty, push, pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  assign x_accept_o    = recognised;
  assign x_writeback_o = recognised & ~dec_st;
  assign x_is_mem_op_o = dec_ld | dec_st;
  assign x_ready_o     = ~recognised | (~full & rs_ok & (x_rd_clean_i | ~x_writeback_o));
  assign push          = x_valid_i & x_ready_o & recognised & ~full;

  always_ff @(posedge clk_i) begin
    if (push) begin
      q_f3[wr_ptr_q]  <= dec_f3;
      q_rd[wr_ptr_q]  <= dec_rd;
      q_rs1[wr_ptr_q] <= x_rs_i[31:0];
      q_rs2[wr_ptr_q] <= x_rs_i[63:32];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (!push && pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  logic [2:0]  h_f3;
  logic [4:0]  h_rd;
  logic [31:0] h_rs1, h_rs2, h_rs3;
  logic        h_is_ld, h_is_st;

  assign h_f3    = q_f3[rd_ptr_q];
  assign h_rd    = q_rd[rd_ptr_q];
  assign h_rs1   = q_rs1[rd_ptr_q];
  assign h_rs2   = q_rs2[rd_ptr_q];
  assign h_is_ld = (h_f3 == 3'b100);
  assign h_is_st = (h_f3 == 3'b101);

`ifdef CV32E40P_X_ACC_MAC_EN
  logic [31:0] q_rs3 [DEPTH];

  always_ff @(posedge clk_i) begin
    if (push) q_rs3[wr_ptr_q] <= x_rs_i[95:64];
  end

  assign h_rs3 = q_rs3[rd_ptr_q];

  logic unused_bits;
  assign unused_bits = ^x_instr_i[31:15];
`else
  assign h_rs3 = '0;

  logic unused_bits;
  assign unused_bits = ^{x_instr_i[31:15], x_rs_i[95:64], h_rs3};
`endif

  logic [31:0] alu_res;

  always_comb begin
    alu_res = h_rs1 + h_rs2;
    case (h_f3)
      3'b001:  alu_res = h_rs1 - h_rs2;
      3'b010:  alu_res = h_rs1 * h_rs2;
      3'b011:  alu_res = h_rs1 * h_rs2 + h_rs3;
      default: alu_res = h_rs1 + h_rs2;
    endcase
  end

  // Next-state and pop logic
  logic [CW-1:0] cnt_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE:    if (!empty) state_d = (h_is_ld || h_is_st) ? MEM_REQ : EXEC;
      EXEC:    if (cnt_q == '0) state_d = RESULT;
      MEM_REQ: if (xmem_ready_i) state_d = MEM_RSP;
      MEM_RSP: begin
        if (xmem_rvalid_i) begin
          if (h_is_st) begin
            pop     = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = RESULT;
          end
        end
      end
      RESULT: begin
        if (x_rready_i) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [31:0] res_data_q;
  logic [4:0]  res_rd_q;
  logic        err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && !empty && !h_is_ld && !h_is_st) cnt_q <= CW'(LATENCY - 1);
      if (state_q == EXEC) begin
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CW'(1);
        end else begin
          res_data_q <= alu_res;
          res_rd_q   <= h_rd;
        end
      end
      if (state_q == MEM_RSP && xmem_rvalid_i) begin
        if (!xmem_status_i) err_q <= 1'b1;
        if (!h_is_st) begin
          res_data_q <= xmem_status_i ? xmem_rdata_i : 32'h0;
          res_rd_q   <= h_rd;
        end
      end
    end
  end

  assign x_rvalid_o      = (state_q == RESULT);
  assign x_rdata_o       = x_rvalid_o ? res_data_q : 32'h0;
  assign x_rwaddr_o      = x_rvalid_o ? res_rd_q : 5'h0;
  assign xmem_valid_o    = (state_q == MEM_REQ);
  assign xmem_req_type_o = (xmem_valid_o && h_is_st) ? WRITE : READ;
  assign xmem_addr_o     = xmem_valid_o ? h_rs1 : 32'h0;
  assign xmem_wdata_o    = (xmem_valid_o && h_is_st) ? h_rs2 : 32'h0;
  assign xmem_rready_o   = (state_q == MEM_RSP);
  assign err_o           = err_q;

endmodule

// File: tb/tb_cv32e40p_x_acc_resp.sv
// tb/tb_cv32e40p_x_acc_resp.sv - directed self-checking bench for cv32e40p_x_acc_resp.
// MAC step is included when CV32E40P_X_ACC_MAC_EN is defined.

module tb_cv32e40p_x_acc_resp;
  import cv32e40p_x_if_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          x_valid_i;
  logic          x_ready_o;
  logic [31:0]   x_instr_i;
  logic [95:0]   x_rs_i;
  logic [2:0]    x_rs_valid_i;
  logic          x_rd_clean_i;
  logic          x_accept_o;
  logic          x_writeback_o;
  logic          x_is_mem_op_o;
  logic          x_rvalid_o;
  logic          x_rready_i;
  logic [4:0]    x_rwaddr_o;
  logic [31:0]   x_rdata_o;
  logic          xmem_valid_o;
  logic          xmem_ready_i;
  mem_req_type_e xmem_req_type_o;
  logic [31:0]   xmem_addr_o;
  logic [31:0]   xmem_wdata_o;
  logic          xmem_rvalid_i;
  logic          xmem_rready_o;
  logic [31:0]   xmem_rdata_i;
  logic          xmem_status_i;
  logic          err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  cv32e40p_x_acc_resp #(.DEPTH(4), .LATENCY(2), .OPCODE(7'h0B)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .x_instr_i(x_instr_i),
    .x_rs_i(x_rs_i), .x_rs_valid_i(x_rs_valid_i), .x_rd_clean_i(x_rd_clean_i),
    .x_accept_o(x_accept_o), .x_writeback_o(x_writeback_o), .x_is_mem_op_o(x_is_mem_op_o),
    .x_rvalid_o(x_rvalid_o), .x_rready_i(x_rready_i), .x_rwaddr_o(x_rwaddr_o), .x_rdata_o(x_rdata_o),
    .xmem_valid_o(xmem_valid_o), .xmem_ready_i(xmem_ready_i), .xmem_req_type_o(xmem_req_type_o),
    .xmem_addr_o(xmem_addr_o), .xmem_wdata_o(xmem_wdata_o), .xmem_rvalid_i(xmem_rvalid_i),
    .xmem_rready_o(xmem_rready_o), .xmem_rdata_i(xmem_rdata_i), .xmem_status_i(xmem_status_i),
    .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {17'b0, f3, rd, op};
  endfunction

  task automatic offer(input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] rs3);
    x_instr_i = enc(f3, rd, 7'h0B);
    x_rs_i    = {rs3, rs2, rs1};
    x_valid_i = 1'b1;
    #1;
  endtask

  task automatic wait_result(input string tag, input logic [4:0] erd, input logic [31:0] edata);
    int n = 0;
    while (!x_rvalid_o && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_rvalid"}, {31'b0, x_rvalid_o}, 32'd1);
    chk({tag, "_rd"}, {27'b0, x_rwaddr_o}, {27'b0, erd});
    chk({tag, "_data"}, x_rdata_o, edata);
    tick();
  endtask

  task automatic wait_mem(input string tag);
    int n = 0;
    while (!xmem_valid_o && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_xmem_valid"}, {31'b0, xmem_valid_o}, 32'd1);
  endtask

  initial begin
    rst_ni        = 1'b0;
    x_valid_i     = 1'b0;
    x_instr_i     = 32'h0;
    x_rs_i        = '0;
    x_rs_valid_i  = 3'b111;
    x_rd_clean_i  = 1'b1;
    x_rready_i    = 1'b0;
    xmem_ready_i  = 1'b0;
    xmem_rvalid_i = 1'b0;
    xmem_rdata_i  = 32'h0;
    xmem_status_i = 1'b1;
    tick();
    tick();
    chk("rst_rvalid", {31'b0, x_rvalid_o}, 32'd0);
    chk("rst_xmem_valid", {31'b0, xmem_valid_o}, 32'd0);
    chk("rst_xmem_rready", {31'b0, xmem_rready_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_rdata", x_rdata_o, 32'd0);
    chk("rst_rwaddr", {27'b0, x_rwaddr_o}, 32'd0);
    chk("rst_addr", xmem_addr_o, 32'd0);
    chk("rst_wdata", xmem_wdata_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    // ADD overflow wrap, latency and result hold
    offer(3'b000, 5'd5, 32'h7FFF_FFFF, 32'h1, 32'h0);
    chk("add_accept", {31'b0, x_accept_o}, 32'd1);
    chk("add_wb", {31'b0, x_writeback_o}, 32'd1);
    chk("add_memop", {31'b0, x_is_mem_op_o}, 32'd0);
    chk("add_ready", {31'b0, x_ready_o}, 32'd1);
    tick();
    x_valid_i = 1'b0;
    #1;
    chk("add_c1_rvalid", {31'b0, x_rvalid_o}, 32'd0);
    tick();
    tick();
    chk("add_c3_rvalid", {31'b0, x_rvalid_o}, 32'd0);
    tick();
    chk("add_c4_rvalid", {31'b0, x_rvalid_o}, 32'd1);
    chk("add_c4_rd", {27'b0, x_rwaddr_o}, 32'd5);
    chk("add_c4_data", x_rdata_o, 32'h8000_0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("add_hold_rvalid", {31'b0, x_rvalid_o}, 32'd1);
      chk("add_hold_rd", {27'b0, x_rwaddr_o}, 32'd5);
      chk("add_hold_data", x_rdata_o, 32'h8000_0000);
    end
    x_rready_i = 1'b1;
    tick();
    x_rready_i = 1'b0;
    #1;
    chk("add_popped", {31'b0, x_rvalid_o}, 32'd0);

    // Unrecognised opcode completes immediately and is never queued
    x_instr_i = {17'b0, 3'b000, 5'd4, 7'h33};
    x_valid_i = 1'b1;
    #1;
    chk("unrec_ready", {31'b0, x_ready_o}, 32'd1);
    chk("unrec_accept", {31'b0, x_accept_o}, 32'd0);
    tick();
    x_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("unrec_no_rvalid", {31'b0, x_rvalid_o}, 32'd0);
    chk("unrec_no_xmem", {31'b0, xmem_valid_o}, 32'd0);
`ifndef CV32E40P_X_ACC_MAC_EN
    x_instr_i    = enc(3'b011, 5'd3, 7'h0B);
    x_rs_valid_i = 3'b000;
    #1;
    chk("mac_off_accept", {31'b0, x_accept_o}, 32'd0);
    chk("mac_off_ready", {31'b0, x_ready_o}, 32'd1);
    x_rs_valid_i = 3'b111;
`endif

    // SUB stalled on rs2 valid
    x_rs_valid_i = 3'b101;
    offer(3'b001, 5'd7, 32'd10, 32'd3, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("sub_stall_ready", {31'b0, x_ready_o}, 32'd0);
      tick();
    end
    x_rs_valid_i = 3'b111;
    #1;
    chk("sub_go_ready", {31'b0, x_ready_o}, 32'd1);
    tick();
    x_valid_i = 1'b0;
    x_rready_i = 1'b1;
    wait_result("sub", 5'd7, 32'd7);
    x_rready_i = 1'b0;

    // rd not clean stalls writers only
    x_rd_clean_i = 1'b0;
    x_instr_i    = enc(3'b000, 5'd8, 7'h0B);
    #1;
    chk("dirty_add_ready", {31'b0, x_ready_o}, 32'd0);
    x_instr_i = enc(3'b101, 5'd8, 7'h0B);
    #1;
    chk("dirty_st_ready", {31'b0, x_ready_o}, 32'd1);
    chk("st_wb", {31'b0, x_writeback_o}, 32'd0);
    chk("st_memop", {31'b0, x_is_mem_op_o}, 32'd1);
    x_rd_clean_i = 1'b1;
    tick();

    // Queue fill: four MULs fit, the fifth waits for a pop
    offer(3'b010, 5'd1, 32'd3, 32'd5, 32'h0);
    chk("mul1_ready", {31'b0, x_ready_o}, 32'd1);
    tick();
    offer(3'b010, 5'd2, 32'hFFFF_FFFF, 32'd2, 32'h0);
    chk("mul2_ready", {31'b0, x_ready_o}, 32'd1);
    tick();
    offer(3'b010, 5'd3, 32'd4, 32'd4, 32'h0);
    chk("mul3_ready", {31'b0, x_ready_o}, 32'd1);
    tick();
    offer(3'b010, 5'd4, 32'd0, 32'd9, 32'h0);
    chk("mul4_ready", {31'b0, x_ready_o}, 32'd1);
    tick();
    offer(3'b010, 5'd6, 32'd7, 32'd6, 32'h0);
    chk("mul5_full_ready", {31'b0, x_ready_o}, 32'd0);
    chk("mul1_rvalid", {31'b0, x_rvalid_o}, 32'd1);
    chk("mul1_rd", {27'b0, x_rwaddr_o}, 32'd1);
    chk("mul1_data", x_rdata_o, 32'd15);
    tick();
    tick();
    chk("mul5_still_full", {31'b0, x_ready_o}, 32'd0);
    x_rready_i = 1'b1;
    #1;
    chk("mul5_full_on_pop", {31'b0, x_ready_o}, 32'd0);
    tick();
    chk("mul5_after_pop", {31'b0, x_ready_o}, 32'd1);
    tick();
    x_valid_i = 1'b0;
    wait_result("mul2", 5'd2, 32'hFFFF_FFFE);
    wait_result("mul3", 5'd3, 32'd16);
    wait_result("mul4", 5'd4, 32'd0);
    wait_result("mul5", 5'd6, 32'd42);
    x_rready_i = 1'b0;

    // LOAD through xmem with delayed ready
    offer(3'b100, 5'd9, 32'h1000, 32'hAAAA_AAAA, 32'h0);
    tick();
    x_valid_i = 1'b0;
    wait_mem("ld");
    chk("ld_type", {31'b0, xmem_req_type_o}, {31'b0, READ});
    chk("ld_addr", xmem_addr_o, 32'h1000);
    chk("ld_wdata", xmem_wdata_o, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("ld_hold_valid", {31'b0, xmem_valid_o}, 32'd1);
      chk("ld_hold_addr", xmem_addr_o, 32'h1000);
    end
    xmem_ready_i = 1'b1;
    tick();
    xmem_ready_i = 1'b0;
    #1;
    chk("ld_rsp_rready", {31'b0, xmem_rready_o}, 32'd1);
    chk("ld_rsp_valid", {31'b0, xmem_valid_o}, 32'd0);
    xmem_rvalid_i = 1'b1;
    xmem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    xmem_rvalid_i = 1'b0;
    #1;
    chk("ld_rvalid", {31'b0, x_rvalid_o}, 32'd1);
    chk("ld_rd", {27'b0, x_rwaddr_o}, 32'd9);
    chk("ld_data", x_rdata_o, 32'hDEAD_BEEF);
    x_rready_i = 1'b1;
    tick();
    x_rready_i = 1'b0;

    // STORE with an error response
    offer(3'b101, 5'd0, 32'h2000, 32'h55, 32'h0);
    tick();
    x_valid_i = 1'b0;
    wait_mem("st");
    chk("st_type", {31'b0, xmem_req_type_o}, {31'b0, WRITE});
    chk("st_addr", xmem_addr_o, 32'h2000);
    chk("st_wdata", xmem_wdata_o, 32'h55);
    xmem_ready_i = 1'b1;
    tick();
    xmem_ready_i  = 1'b0;
    xmem_rvalid_i = 1'b1;
    xmem_status_i = 1'b0;
    tick();
    xmem_rvalid_i = 1'b0;
    xmem_status_i = 1'b1;
    #1;
    chk("st_err", {31'b0, err_o}, 32'd1);
    chk("st_no_rvalid", {31'b0, x_rvalid_o}, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("st_err_sticky", {31'b0, err_o}, 32'd1);
    chk("st_no_rvalid_late", {31'b0, x_rvalid_o}, 32'd0);

    // Reset in MEM_REQ with three queued entries
    offer(3'b100, 5'd1, 32'h3000, 32'h0, 32'h0);
    tick();
    offer(3'b000, 5'd2, 32'd1, 32'd1, 32'h0);
    tick();
    offer(3'b000, 5'd3, 32'd2, 32'd2, 32'h0);
    tick();
    x_valid_i = 1'b0;
    #1;
    chk("rstmid_memreq", {31'b0, xmem_valid_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rstmid_xmem_drop", {31'b0, xmem_valid_o}, 32'd0);
    chk("rstmid_rvalid", {31'b0, x_rvalid_o}, 32'd0);
    chk("rstmid_err", {31'b0, err_o}, 32'd0);
    tick();
    rst_ni    = 1'b1;
    x_instr_i = enc(3'b000, 5'd2, 7'h0B);
    #1;
    chk("rstmid_ready", {31'b0, x_ready_o}, 32'd1);
    for (int i = 0; i < 8; i++) tick();
    chk("rstmid_idle_xmem", {31'b0, xmem_valid_o}, 32'd0);
    chk("rstmid_idle_rvalid", {31'b0, x_rvalid_o}, 32'd0);

`ifdef CV32E40P_X_ACC_MAC_EN
    x_rs_valid_i = 3'b011;
    offer(3'b011, 5'd3, 32'd2, 32'd3, 32'd4);
    chk("mac_rs3_stall", {31'b0, x_ready_o}, 32'd0);
    x_rs_valid_i = 3'b111;
    #1;
    chk("mac_accept", {31'b0, x_accept_o}, 32'd1);
    chk("mac_ready", {31'b0, x_ready_o}, 32'd1);
    tick();
    x_valid_i  = 1'b0;
    x_rready_i = 1'b1;
    wait_result("mac", 5'd3, 32'd10);
    x_rready_i = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
